// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, entry types and result-bus snoop helper for the ALU reservation station.
package alu_rs_pkg;

    localparam int OP_WIDTH     = 7;
    localparam int VAL_WIDTH    = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int ROB_ID_WIDTH = 3;
    localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;

    typedef struct packed {
        logic                 pend;
        logic [TAG_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0] val;
    } operand_t;

    typedef struct packed {
        logic                  busy;
        logic [OP_WIDTH-1:0]   op_type;
        operand_t              j;
        operand_t              k;
        logic [TAG_WIDTH-1:0]  entry;
        logic [ADDR_WIDTH-1:0] pc;
    } rs_entry_t;

    // The ALU bus is checked first so it wins when both buses carry the same tag.
    function automatic operand_t snoop(
        input operand_t             o,
        input logic                 alu_v,
        input logic [TAG_WIDTH-1:0] alu_t,
        input logic [VAL_WIDTH-1:0] alu_val,
        input logic                 lsb_v,
        input logic [TAG_WIDTH-1:0] lsb_t,
        input logic [VAL_WIDTH-1:0] lsb_val
    );
        operand_t r;
        r = o;
        if (o.pend && alu_v && o.tag == alu_t) begin
            r.pend = 1'b0;
            r.val  = alu_val;
        end else if (o.pend && lsb_v && o.tag == lsb_t) begin
            r.pend = 1'b0;
            r.val  = lsb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: combinational lowest-index priority encoder over an N-bit request vector.
module rs_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; buffers ops, wakes operands from result buses, dispatches one ready op per cycle.
// Define RS_LSB_CDB_EN to add the load-store buffer result bus to wakeup and issue bypass.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = 8,
    parameter int IDX_WIDTH = $clog2(RS_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  issue_in,
    input  logic [OP_WIDTH-1:0]   issue_type,
    input  logic [VAL_WIDTH-1:0]  issue_vj,
    input  logic [VAL_WIDTH-1:0]  issue_vk,
    input  logic [TAG_WIDTH-1:0]  issue_qj,
    input  logic [TAG_WIDTH-1:0]  issue_qk,
    input  logic                  issue_qj_valid,
    input  logic                  issue_qk_valid,
    input  logic [TAG_WIDTH-1:0]  issue_entry,
    input  logic [ADDR_WIDTH-1:0] issue_pc,
    output logic                  rs_full,
    input  logic                  alu_cdb_valid,
    input  logic [TAG_WIDTH-1:0]  alu_cdb_entry,
    input  logic [VAL_WIDTH-1:0]  alu_cdb_val,
`ifdef RS_LSB_CDB_EN
    input  logic                  lsb_cdb_valid,
    input  logic [TAG_WIDTH-1:0]  lsb_cdb_entry,
    input  logic [VAL_WIDTH-1:0]  lsb_cdb_val,
`endif
    output logic                  execute,
    output logic [OP_WIDTH-1:0]   op_type,
    output logic [VAL_WIDTH-1:0]  val1,
    output logic [VAL_WIDTH-1:0]  val2,
    output logic [TAG_WIDTH-1:0]  entry,
    output logic [ADDR_WIDTH-1:0] nowPC
);

    rs_entry_t             ent_q [RS_SIZE];
    rs_entry_t             ent_d [RS_SIZE];
    logic [RS_SIZE-1:0]    ready, busy, busy_d;
    logic [IDX_WIDTH-1:0]  sel_idx, free_idx;
    logic                  sel_found, free_found;
    logic                  execute_d, execute_q, full_d, full_q;
    logic [OP_WIDTH-1:0]   type_d, type_q;
    logic [VAL_WIDTH-1:0]  val1_d, val1_q, val2_d, val2_q;
    logic [TAG_WIDTH-1:0]  entry_d, entry_q;
    logic [ADDR_WIDTH-1:0] pc_d, pc_q;
    logic                  lsb_v;
    logic [TAG_WIDTH-1:0]  lsb_t;
    logic [VAL_WIDTH-1:0]  lsb_val;

`ifdef RS_LSB_CDB_EN
    assign lsb_v   = lsb_cdb_valid;
    assign lsb_t   = lsb_cdb_entry;
    assign lsb_val = lsb_cdb_val;
`else
    assign lsb_v   = 1'b0;
    assign lsb_t   = '0;
    assign lsb_val = '0;
`endif

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && !ent_q[i].j.pend && !ent_q[i].k.pend;
        end
    end

    rs_select #(.N(RS_SIZE), .W(IDX_WIDTH)) u_sel  (.req(ready), .idx(sel_idx),  .found(sel_found));
    rs_select #(.N(RS_SIZE), .W(IDX_WIDTH)) u_free (.req(~busy), .idx(free_idx), .found(free_found));

    // Free slot comes from pre-edge busy, so a slot vacated by this edge's select is not reused.
    always_comb begin
        ent_d     = ent_q;
        execute_d = 1'b0;
        type_d    = type_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        entry_d   = entry_q;
        pc_d      = pc_q;
        if (rdy_in && clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].j = snoop(ent_q[i].j, alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_v, lsb_t, lsb_val);
                    ent_d[i].k = snoop(ent_q[i].k, alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_v, lsb_t, lsb_val);
                end
            end
            if (sel_found) begin
                execute_d           = 1'b1;
                type_d              = ent_q[sel_idx].op_type;
                val1_d              = ent_q[sel_idx].j.val;
                val2_d              = ent_q[sel_idx].k.val;
                entry_d             = ent_q[sel_idx].entry;
                pc_d                = ent_q[sel_idx].pc;
                ent_d[sel_idx].busy = 1'b0;
            end
            if (issue_in && free_found) begin
                ent_d[free_idx] = '{
                    busy:    1'b1,
                    op_type: issue_type,
                    j:       snoop('{pend: issue_qj_valid, tag: issue_qj, val: issue_vj},
                                   alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_v, lsb_t, lsb_val),
                    k:       snoop('{pend: issue_qk_valid, tag: issue_qk, val: issue_vk},
                                   alu_cdb_valid, alu_cdb_entry, alu_cdb_val, lsb_v, lsb_t, lsb_val),
                    entry:   issue_entry,
                    pc:      issue_pc
                };
            end
        end
        for (int i = 0; i < RS_SIZE; i++) busy_d[i] = ent_d[i].busy;
        full_d = &busy_d;
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            execute_q <= 1'b0;
            full_q    <= 1'b0;
            type_q    <= '0;
            val1_q    <= '0;
            val2_q    <= '0;
            entry_q   <= '0;
            pc_q      <= '0;
        end else begin
            ent_q     <= ent_d;
            execute_q <= execute_d;
            full_q    <= full_d;
            type_q    <= type_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            entry_q   <= entry_d;
            pc_q      <= pc_d;
        end
    end

    assign rs_full = full_q;
    assign execute = execute_q;
    assign op_type = type_q;
    assign val1    = val1_q;
    assign val2    = val2_q;
    assign entry   = entry_q;
    assign nowPC   = pc_q;

endmodule
